// File: rtl/vregfile.sv
// Vector register file with byte-masked write, write-first registered read ports,
// a per-register busy scoreboard, and a continuously exported v0 mask source.
module vregfile #(
  parameter int VLEN       = 128,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RPORTS = 3,
  localparam int AW        = $clog2(NUM_REGS),
  localparam int NB        = VLEN / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RPORTS-1:0]      rd_en_i,
  input  logic [NUM_RPORTS*AW-1:0]   rd_addr_i,
  output logic [NUM_RPORTS*VLEN-1:0] rd_data_o,
  output logic [NUM_RPORTS-1:0]      rd_valid_o,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [VLEN-1:0]            wr_data_i,
  input  logic [NB-1:0]              wr_be_i,
  input  logic                       wr_release_i,
  input  logic                       rsv_en_i,
  input  logic [AW-1:0]              rsv_addr_i,
  input  logic                       flush_i,
  output logic [NUM_REGS-1:0]        busy_o,
  output logic [VLEN-1:0]            v0_o
);

  logic [VLEN-1:0]     mem [NUM_REGS];
  logic [VLEN-1:0]     wr_merged;
  logic [VLEN-1:0]     rd_next [NUM_RPORTS];
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    wr_merged = mem[wr_addr_i];
    for (int b = 0; b < NB; b++) begin
      if (wr_be_i[b]) wr_merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end

  // Reads on the write edge see the merged post-write word.
  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rd_next[p] = mem[rd_addr_i[p*AW +: AW]];
      if (wr_en_i && (wr_addr_i == rd_addr_i[p*AW +: AW])) rd_next[p] = wr_merged;
    end
  end

  // Later assignments win: release < reserve < flush.
  always_comb begin
    busy_next = busy_o;
    if (wr_en_i && wr_release_i) busy_next[wr_addr_i] = 1'b0;
    if (rsv_en_i)                busy_next[rsv_addr_i] = 1'b1;
    if (flush_i)                 busy_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else if (wr_en_i) begin
      mem[wr_addr_i] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      for (int p = 0; p < NUM_RPORTS; p++) begin
        if (rd_en_i[p]) rd_data_o[p*VLEN +: VLEN] <= rd_next[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_o <= '0;
    else        busy_o <= busy_next;
  end

  assign v0_o = mem[0];

endmodule

// File: tb/tb_vregfile.sv
// Directed, table-driven bench for vregfile at default parameters.
module tb_vregfile;

  localparam int VLEN = 128;
  localparam int NR   = 32;
  localparam int NP   = 3;
  localparam int AW   = 5;
  localparam int NB   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    rd_en_i = '0;
  logic [NP*AW-1:0] rd_addr_i = '0;
  logic [NP*VLEN-1:0] rd_data_o;
  logic [NP-1:0]    rd_valid_o;
  logic             wr_en_i = 1'b0;
  logic [AW-1:0]    wr_addr_i = '0;
  logic [VLEN-1:0]  wr_data_i = '0;
  logic [NB-1:0]    wr_be_i = '0;
  logic             wr_release_i = 1'b0;
  logic             rsv_en_i = 1'b0;
  logic [AW-1:0]    rsv_addr_i = '0;
  logic             flush_i = 1'b0;
  logic [NR-1:0]    busy_o;
  logic [VLEN-1:0]  v0_o;

  vregfile dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .wr_release_i(wr_release_i), .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .v0_o(v0_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [VLEN-1:0] wr_data;
    logic [NB-1:0]   wr_be;
    logic            wr_rel;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;
    logic [NP-1:0]   rd_en;
    logic [AW-1:0]   ra0, ra1, ra2;
    logic [NP-1:0]   chk;
    logic [VLEN-1:0] e0, e1, e2;
    logic [NR-1:0]   e_busy;
    logic [NP-1:0]   e_valid;
    logic [VLEN-1:0] e_v0;
  } vec_t;

  vec_t vq[$];
  vec_t t;
  int n_chk = 0;
  int n_fail = 0;

  logic [VLEN-1:0] ONES, A5, V5M, V3M, V0W;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    wr_en_i      = v.wr_en;
    wr_addr_i    = v.wr_addr;
    wr_data_i    = v.wr_data;
    wr_be_i      = v.wr_be;
    wr_release_i = v.wr_rel;
    rsv_en_i     = v.rsv_en;
    rsv_addr_i   = v.rsv_addr;
    flush_i      = v.flush;
    rd_en_i      = v.rd_en;
    rd_addr_i    = {v.ra2, v.ra1, v.ra0};
  endtask

  initial begin
    ONES = '1;
    A5   = {16{8'hA5}};
    V5M  = {{15{8'hFF}}, 8'h00};
    V3M  = {8'h00, {15{8'hA5}}};
    V0W  = 128'h1234;

    // 0: fill v5 with ones
    t = '0; t.wr_en = 1; t.wr_addr = 5; t.wr_data = ONES; t.wr_be = '1; vq.push_back(t);
    // 1: clear only byte 0 of v5
    t = '0; t.wr_en = 1; t.wr_addr = 5; t.wr_data = '0; t.wr_be = 16'h0001; vq.push_back(t);
    // 2: read v5
    t = '0; t.rd_en = 3'b001; t.ra0 = 5; t.chk = 3'b001; t.e0 = V5M; t.e_valid = 3'b001; vq.push_back(t);
    // 3: write v3 with all ports reading it on the same edge
    t = '0; t.wr_en = 1; t.wr_addr = 3; t.wr_data = A5; t.wr_be = '1;
    t.rd_en = 3'b111; t.ra0 = 3; t.ra1 = 3; t.ra2 = 3; t.chk = 3'b111;
    t.e0 = A5; t.e1 = A5; t.e2 = A5; t.e_valid = 3'b111; vq.push_back(t);
    // 4: write v0, read data must hold
    t = '0; t.wr_en = 1; t.wr_addr = 0; t.wr_data = V0W; t.wr_be = '1;
    t.chk = 3'b111; t.e0 = A5; t.e1 = A5; t.e2 = A5; t.e_v0 = V0W; vq.push_back(t);
    // 5: reserve v7
    t = '0; t.rsv_en = 1; t.rsv_addr = 7; t.e_busy = 32'h80; t.e_v0 = V0W; vq.push_back(t);
    // 6: release and reserve v7 together; reserve wins
    t = '0; t.wr_en = 1; t.wr_addr = 7; t.wr_rel = 1; t.rsv_en = 1; t.rsv_addr = 7;
    t.e_busy = 32'h80; t.e_v0 = V0W; vq.push_back(t);
    // 7: release alone with no byte enables; data untouched
    t = '0; t.wr_en = 1; t.wr_addr = 7; t.wr_data = ONES; t.wr_rel = 1;
    t.rd_en = 3'b010; t.ra1 = 7; t.chk = 3'b010; t.e1 = '0; t.e_valid = 3'b010;
    t.e_busy = 32'h0; t.e_v0 = V0W; vq.push_back(t);
    // 8..10: reserve v1, v2, v31
    t = '0; t.rsv_en = 1; t.rsv_addr = 1;  t.e_busy = 32'h2;        t.e_v0 = V0W; vq.push_back(t);
    t = '0; t.rsv_en = 1; t.rsv_addr = 2;  t.e_busy = 32'h6;        t.e_v0 = V0W; vq.push_back(t);
    t = '0; t.rsv_en = 1; t.rsv_addr = 31; t.e_busy = 32'h80000006; t.e_v0 = V0W; vq.push_back(t);
    // 11: flush beats a same-edge reservation
    t = '0; t.flush = 1; t.rsv_en = 1; t.rsv_addr = 9; t.e_busy = 32'h0; t.e_v0 = V0W; vq.push_back(t);
    // 12: data survives flush
    t = '0; t.rd_en = 3'b111; t.ra0 = 5; t.ra1 = 3; t.ra2 = 0; t.chk = 3'b111;
    t.e0 = V5M; t.e1 = A5; t.e2 = V0W; t.e_valid = 3'b111; t.e_v0 = V0W; vq.push_back(t);
    // 13..14: reserving an already-busy register
    t = '0; t.rsv_en = 1; t.rsv_addr = 4; t.e_busy = 32'h10; t.e_v0 = V0W; vq.push_back(t);
    t = '0; t.rsv_en = 1; t.rsv_addr = 4; t.e_busy = 32'h10; t.e_v0 = V0W; vq.push_back(t);
    // 15: release a non-busy reg via a top-byte write of v3, bypassed per byte
    t = '0; t.wr_en = 1; t.wr_addr = 3; t.wr_data = '0; t.wr_be = 16'h8000; t.wr_rel = 1;
    t.rd_en = 3'b001; t.ra0 = 3; t.chk = 3'b111; t.e0 = V3M; t.e1 = A5; t.e2 = V0W;
    t.e_valid = 3'b001; t.e_busy = 32'h10; t.e_v0 = V0W; vq.push_back(t);
    // 16: idle, read data holds
    t = '0; t.chk = 3'b001; t.e0 = V3M; t.e_busy = 32'h10; t.e_v0 = V0W; vq.push_back(t);

    // reset state
    #2;
    chk("reset rd_valid", VLEN'(rd_valid_o), '0);
    chk("reset rd_data", rd_data_o[VLEN-1:0], '0);
    chk("reset busy", VLEN'(busy_o), '0);
    chk("reset v0", v0_o, '0);
    #10;
    rst_n = 1'b1;
    #10;

    // read every register on port 0 back-to-back
    for (int r = 0; r < NR; r++) begin
      rd_en_i = 3'b001;
      rd_addr_i = '0;
      rd_addr_i[AW-1:0] = AW'(r);
      step();
      chk($sformatf("init rd v%0d", r), rd_data_o[VLEN-1:0], '0);
      chk($sformatf("init valid v%0d", r), VLEN'(rd_valid_o), VLEN'(3'b001));
      chk($sformatf("init busy v%0d", r), VLEN'(busy_o), '0);
    end

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      step();
      chk($sformatf("vec%0d busy", i), VLEN'(busy_o), VLEN'(vq[i].e_busy));
      chk($sformatf("vec%0d valid", i), VLEN'(rd_valid_o), VLEN'(vq[i].e_valid));
      chk($sformatf("vec%0d v0", i), v0_o, vq[i].e_v0);
      if (vq[i].chk[0]) chk($sformatf("vec%0d rd0", i), rd_data_o[0*VLEN +: VLEN], vq[i].e0);
      if (vq[i].chk[1]) chk($sformatf("vec%0d rd1", i), rd_data_o[1*VLEN +: VLEN], vq[i].e1);
      if (vq[i].chk[2]) chk($sformatf("vec%0d rd2", i), rd_data_o[2*VLEN +: VLEN], vq[i].e2);
    end

    // asynchronous reset in the middle of a read stream
    t = '0; drive(t);
    rd_en_i = 3'b001;
    rd_addr_i = '0;
    rd_addr_i[AW-1:0] = 5'd3;
    step();
    chk("pre-rst rd", rd_data_o[VLEN-1:0], V3M);
    chk("pre-rst valid", VLEN'(rd_valid_o), VLEN'(3'b001));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst valid", VLEN'(rd_valid_o), '0);
    chk("mid-rst rd", rd_data_o[VLEN-1:0], '0);
    chk("mid-rst busy", VLEN'(busy_o), '0);
    chk("mid-rst v0", v0_o, '0);
    #3;
    rst_n = 1'b1;
    step();
    chk("post-rst rd", rd_data_o[VLEN-1:0], '0);
    chk("post-rst valid", VLEN'(rd_valid_o), VLEN'(3'b001));
    rd_en_i = '0;
    step();
    chk("post-rst idle valid", VLEN'(rd_valid_o), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vregfile.md
# vregfile

Parametrised vector register file for the vector datapath: NUM_REGS registers of VLEN bits each, with NUM_RPORTS registered read ports, one byte-masked write port, and a per-register busy scoreboard. It sits beside the scalar register file. The vector issue stage reads operands and reserves destinations here. The vector writeback stage writes results and releases reservations. Unlike the scalar file, v0 is a normal writable register, and its contents are exported continuously as the mask source.

## Interface
Parameters:
- VLEN, 128, register width in bits; multiple of 8, at least 32
- NUM_REGS, 32, register count; power of 2, at least 2; AW = $clog2(NUM_REGS)
- NUM_RPORTS, 3, independent read ports; at least 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rd_en_i  in  NUM_RPORTS  per-port read request
- rd_addr_i  in  NUM_RPORTS*AW  per-port read address; port p uses slice [p*AW +: AW]
- rd_data_o  out  NUM_RPORTS*VLEN  per-port read data; port p uses slice [p*VLEN +: VLEN]
- rd_valid_o  out  NUM_RPORTS  per-port data valid, one cycle after request
- wr_en_i  in  1  write enable
- wr_addr_i  in  AW  write address
- wr_data_i  in  VLEN  write data
- wr_be_i  in  VLEN/8  byte enables; bit b covers bits [8b+7:8b]
- wr_release_i  in  1  when set with wr_en_i, clears the busy bit of wr_addr_i
- rsv_en_i  in  1  reserve a destination (sets its busy bit)
- rsv_addr_i  in  AW  register to reserve
- flush_i  in  1  clears all busy bits; register data is not affected
- busy_o  out  NUM_REGS  scoreboard; bit r set means register r has a pending write
- v0_o  out  VLEN  current contents of register 0

## Operation
- Storage and write:
  - At reset, all registers are 0.
  - A write updates only the bytes whose enable is 1. Bytes with enable 0 keep their old value.
  - Every address is writable, including 0.
  - A write with wr_be_i all 0 changes no data. It still releases the busy bit if wr_release_i is 1.
- Read:
  - On a clock edge with rd_en_i[p]=1, port p captures the register at rd_addr_i[p] into rd_data_o[p].
  - If the write port targets the same address on the same edge, the captured value is the merged post-write value (write-first bypass, per byte).
  - With rd_en_i[p]=0, rd_data_o[p] holds its previous value.
  - Any number of ports may read the same address in the same cycle.
- Scoreboard, with priority flush_i > rsv_en_i > release, evaluated per bit each edge:
  - flush_i=1: every busy bit becomes 0. This includes a bit that rsv_en_i would set on the same edge; flush wins.
  - rsv_en_i=1: busy[rsv_addr_i] becomes 1, even if a release targets the same register on the same edge. The new owner wins.
  - wr_en_i and wr_release_i both 1: busy[wr_addr_i] becomes 0.
  - Reserving a register that is already busy leaves it busy; this is legal.
  - Releasing a register that is not busy leaves it clear; this is legal.
- v0_o is driven directly from the register 0 storage, not through a read port.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - All registers 0
  - rd_data_o all 0
  - rd_valid_o all 0
  - busy_o all 0
  - v0_o 0
- rst_n asserted mid-operation discards any pending reads, writes and reservations. After rst_n rises, the first edge behaves like a fresh cycle.
- Read latency is 1 cycle: request at edge N gives rd_data_o and rd_valid_o at N+1.
  - rd_valid_o[p] is the registered copy of rd_en_i[p].
  - It stays high on back-to-back reads.
- Writes become visible:
  - in storage and v0_o after the write edge;
  - to reads sampled on that same edge, through the bypass.
- busy_o reflects a reservation or release after the edge that applies it. The block has no combinational path from rsv or release inputs to busy_o.
- Read ports never stall. The block has no handshake backpressure; the issue stage must consult busy_o itself.

## Test plan
- Reset, then read all 32 registers on port 0, with default parameters -> every rd_data_o is 0, rd_valid_o is 1 one cycle after each request, and busy_o is 0.
- Write v5=0xFFFF…FF with all byte enables, then write v5=0x0 with wr_be_i=0x0001, then read v5 -> 0xFFFF…FF00. This checks partial-byte merge.
- Write v3=0xA5A5…A5 on the same edge as reads of v3 on all 3 ports -> all ports return 0xA5A5…A5 on the next cycle (bypass).
- Write v0=0x1234 with all byte enables -> v0_o=0x1234 from the next cycle, with no read port used.
- Reserve v7, then on one edge release v7 while reserving v7 -> busy_o[7] stays 1. A later release alone clears it to 0.
- Reserve v1, v2 and v31, then assert flush_i together with rsv_en_i for v9 -> busy_o=0 and register data is unchanged. Also assert rst_n low during a pending read -> rd_valid_o=0 immediately.
